// File: rtl/xlib_dma_wc.sv
// xlib_dma_wc: write DMA, drains a show-ahead FIFO into aligned
// fixed-size bursts on the BIU write port.
module xlib_dma_wc #(
  parameter int AL        = 2,
  parameter int AW        = 32,
  parameter int BL        = 4,
  parameter int FW        = 6,
  parameter int LW        = 24,
  parameter int BLEN_TYPE = 0,
  parameter int DELAY_CNT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pio_adr_we,
  input  logic                   pio_len_we,
  input  logic                   pio_cst_we,
  input  logic [31:0]            pio_d,
  output logic [31:0]            pio_adr,
  output logic [31:0]            pio_len,
  output logic [31:0]            pio_cst,
  input  logic [FW:0]            dff_cnt,
  input  logic [8*(2**AL)-1:0]   dff_q,
  output logic                   dff_ack,
  output logic                   done,
  output logic                   err,
  output logic [AW-1:0]          biu_adr,
  output logic [BL-BLEN_TYPE:0]  biu_len,
  output logic [8*(2**AL)-1:0]   biu_dat,
  output logic                   biu_sob,
  output logic                   biu_eob,
  output logic                   biu_val,
  input  logic                   biu_rdy,
  input  logic                   rsp_val
);

  localparam int SH  = BL + AL;
  localparam int OSW = LW - SH + 1;
  localparam int HW  = $clog2(DELAY_CNT + 1) + 1;
  localparam int NW  = 2 ** BL;
  localparam int LNW = BL - BLEN_TYPE + 1;

  localparam logic [AW-1:0] ADR_STEP = AW'(1) << SH;
  localparam logic [LW-1:0] LEN_STEP = LW'(1) << SH;
  localparam logic [FW:0]   CNT_FULL = (FW + 1)'(1) << BL;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DRAIN
  } state_t;

  state_t          state;
  logic [AW-1:0]   adr;
  logic [LW-1:0]   len;
  logic [BL-1:0]   cnt;
  logic [OSW-1:0]  os;
  logic [HW-1:0]   holdoff;
  logic            done_stk;

  logic busy;
  logic acc;
  logic last;
  logic len_zero;
  logic fin;
  logic err_set;
  logic unused_pio;

  assign busy     = state != IDLE;
  assign acc      = biu_val & biu_rdy;
  assign last     = acc && (cnt == '1);
  assign len_zero = pio_d[LW-1:SH] == '0;
  assign fin      = (state == DRAIN && os == '0) ||
                    (state == IDLE && pio_len_we && len_zero);
  assign err_set  = (busy && (pio_adr_we || pio_len_we)) ||
                    (rsp_val && !last && os == '0);

  // low pio_d bits are alignment padding for adr/len
  assign unused_pio = ^pio_d[SH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      adr     <= '0;
      len     <= '0;
      cnt     <= '0;
      holdoff <= '0;
      done    <= 1'b0;
    end else begin
      done <= fin;
      unique case (state)
        IDLE: begin
          if (pio_adr_we)
            adr <= {pio_d[AW-1:SH], {SH{1'b0}}};
          if (pio_len_we) begin
            len <= {pio_d[LW-1:SH], {SH{1'b0}}};
            if (!len_zero)
              state <= WAIT;
          end
        end
        WAIT: begin
          // holdoff masks a dff_cnt that has not yet seen the last pops
          if (holdoff != '0)
            holdoff <= holdoff - 1'b1;
          if (len == '0)
            state <= DRAIN;
          else if (holdoff == '0 && dff_cnt >= CNT_FULL)
            state <= BURST;
        end
        BURST: begin
          if (acc) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1) begin
              adr     <= adr + ADR_STEP;
              len     <= len - LEN_STEP;
              holdoff <= HW'(DELAY_CNT);
              state   <= WAIT;
            end
          end
        end
        DRAIN: begin
          if (os == '0)
            state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os       <= '0;
      err      <= 1'b0;
      done_stk <= 1'b0;
    end else begin
      if (last && !rsp_val)
        os <= os + 1'b1;
      else if (rsp_val && !last && os != '0)
        os <= os - 1'b1;

      // a set in the same cycle beats a software clear
      if (err_set)
        err <= 1'b1;
      else if (pio_cst_we && pio_d[1])
        err <= 1'b0;

      if (fin)
        done_stk <= 1'b1;
      else if (pio_cst_we && pio_d[2])
        done_stk <= 1'b0;
    end
  end

  assign biu_val = state == BURST;
  assign dff_ack = biu_val & biu_rdy;
  assign biu_dat = dff_q;
  assign biu_sob = biu_val && (cnt == '0);
  assign biu_eob = biu_val && (cnt == '1);
  assign biu_adr = {adr[AW-1:SH], cnt, {AL{1'b0}}};
  assign biu_len = LNW'(BLEN_TYPE != 0 ? NW - 1 : NW);

  assign pio_adr = 32'(adr);
  assign pio_len = 32'(len);
  assign pio_cst = {16'b0, 8'(os), 5'b0, done_stk, err, busy};

endmodule

// File: tb/tb_xlib_dma_wc.sv
// tb_xlib_dma_wc: directed bench for xlib_dma_wc, default build
// plus an AXI-length / DELAY_CNT=1 build.
module tb_xlib_dma_wc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pio_adr_we = 1'b0;
  logic        pio_len_we = 1'b0;
  logic        pio_cst_we = 1'b0;
  logic [31:0] pio_d = '0;
  wire  [31:0] pio_adr, pio_len, pio_cst;
  logic [6:0]  dff_cnt;
  logic [31:0] dff_q;
  wire         dff_ack, done, err;
  wire  [31:0] biu_adr, biu_dat;
  wire  [4:0]  biu_len;
  wire         biu_sob, biu_eob, biu_val;
  logic        biu_rdy = 1'b1;
  logic        rsp_val = 1'b0;

  logic        p1_adr_we = 1'b0;
  logic        p1_len_we = 1'b0;
  logic        p1_cst_we = 1'b0;
  logic        rsp1 = 1'b0;
  wire  [31:0] pio_adr1, pio_len1, pio_cst1;
  logic [6:0]  cnt1_q;
  logic [31:0] dff_q1;
  wire         dff_ack1, done1, err1;
  wire  [31:0] biu_adr1, biu_dat1;
  wire  [3:0]  biu_len1;
  wire         sob1, eob1, val1;

  int fill = 0;
  int pops = 0;
  int fill1 = 0;
  int pops1 = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dff_cnt = 7'(fill - pops);
  assign dff_q   = 32'hA000_0000 + 32'(pops);
  assign dff_q1  = 32'hB000_0000 + 32'(pops1);

  always @(posedge clk) begin
    if (dff_ack) pops <= pops + 1;
    if (dff_ack1) pops1 <= pops1 + 1;
    cnt1_q <= 7'(fill1 - pops1);
  end

  xlib_dma_wc u_dut (
    .clk(clk), .rst(rst),
    .pio_adr_we(pio_adr_we), .pio_len_we(pio_len_we),
    .pio_cst_we(pio_cst_we), .pio_d(pio_d),
    .pio_adr(pio_adr), .pio_len(pio_len), .pio_cst(pio_cst),
    .dff_cnt(dff_cnt), .dff_q(dff_q), .dff_ack(dff_ack),
    .done(done), .err(err),
    .biu_adr(biu_adr), .biu_len(biu_len), .biu_dat(biu_dat),
    .biu_sob(biu_sob), .biu_eob(biu_eob), .biu_val(biu_val),
    .biu_rdy(biu_rdy), .rsp_val(rsp_val)
  );

  xlib_dma_wc #(.BLEN_TYPE(1), .DELAY_CNT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .pio_adr_we(p1_adr_we), .pio_len_we(p1_len_we),
    .pio_cst_we(p1_cst_we), .pio_d(pio_d),
    .pio_adr(pio_adr1), .pio_len(pio_len1), .pio_cst(pio_cst1),
    .dff_cnt(cnt1_q), .dff_q(dff_q1), .dff_ack(dff_ack1),
    .done(done1), .err(err1),
    .biu_adr(biu_adr1), .biu_len(biu_len1), .biu_dat(biu_dat1),
    .biu_sob(sob1), .biu_eob(eob1), .biu_val(val1),
    .biu_rdy(biu_rdy), .rsp_val(rsp1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pio_wr(input logic a, input logic l, input logic c,
                        input logic [31:0] d);
    pio_adr_we = a;
    pio_len_we = l;
    pio_cst_we = c;
    pio_d = d;
    tick();
    pio_adr_we = 1'b0;
    pio_len_we = 1'b0;
    pio_cst_we = 1'b0;
  endtask

  task automatic rsp_pulse();
    rsp_val = 1'b1;
    tick();
    rsp_val = 1'b0;
  endtask

  task automatic wait_val(input string tag);
    int k = 0;
    while (!biu_val && k < 40) begin
      tick();
      k++;
    end
    chk(tag, biu_val, 1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk(tag, done, 1);
    tick();
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic burst(input string tag, input logic [31:0] base,
                       input bit toggle);
    int n = 0;
    int k = 0;
    int p0 = pops;
    logic r;
    while (n < 16 && k < 64) begin
      r = toggle ? (k % 2 == 0) : 1'b1;
      biu_rdy = r;
      #1;
      chk({tag, "_val"}, biu_val, 1);
      chk({tag, "_adr"}, biu_adr, base + 32'(4 * n));
      chk({tag, "_sob"}, biu_sob, n == 0);
      chk({tag, "_eob"}, biu_eob, n == 15);
      chk({tag, "_ack"}, dff_ack, r);
      chk({tag, "_dat"}, biu_dat, 32'hA000_0000 + 32'(p0 + n));
      tick();
      if (r) n++;
      k++;
    end
    biu_rdy = 1'b1;
    chk({tag, "_pops"}, 32'(pops - p0), 16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) tick();
    chk("rst_val", biu_val, 0);
    chk("rst_ack", dff_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cst", pio_cst, 0);
    chk("rst_adr", pio_adr, 0);
    chk("rst_len", pio_len, 0);
    chk("blen_avm", biu_len, 16);
    chk("blen_axi", biu_len1, 15);
    rst = 1'b0;
    tick();

    // single burst
    fill = 16;
    pio_wr(1, 0, 0, 32'h1000);
    chk("t1_adr", pio_adr, 32'h1000);
    pio_wr(0, 1, 0, 32'h40);
    chk("t1_busy", pio_cst[0], 1);
    wait_val("t1_start");
    burst("t1", 32'h1000, 0);
    chk("t1_len", pio_len, 0);
    chk("t1_os", pio_cst[15:8], 1);
    chk("t1_idle_val", biu_val, 0);
    rsp_pulse();
    wait_done("t1_done");
    chk("t1_cst", pio_cst, 32'h4);

    // level gating, busy writes, rdy toggling, drain
    pio_wr(0, 0, 1, 32'h6);
    chk("t2_clr", pio_cst, 0);
    fill = pops + 15;
    pio_wr(1, 0, 0, 32'h2000);
    pio_wr(0, 1, 0, 32'h80);
    repeat (8) tick();
    chk("t2_nolvl", biu_val, 0);
    chk("t2_busy", pio_cst[0], 1);
    pio_wr(0, 1, 0, 32'h40);
    chk("t2_lenbusy_err", pio_cst[1], 1);
    chk("t2_len_kept", pio_len, 32'h80);
    pio_wr(1, 0, 0, 32'h9000);
    chk("t2_adr_kept", pio_adr, 32'h2000);
    pio_wr(0, 0, 1, 32'h2);
    chk("t2_err_clr", pio_cst[1], 0);
    fill = pops + 16;
    wait_val("t2a_start");
    burst("t2a", 32'h2000, 0);
    repeat (4) tick();
    chk("t2_gap_val", biu_val, 0);
    chk("t2_gap_adr", pio_adr, 32'h2040);
    chk("t2_gap_len", pio_len, 32'h40);
    fill = pops + 16;
    wait_val("t2b_start");
    burst("t2b", 32'h2040, 1);
    repeat (4) tick();
    chk("t2_drain_cst", pio_cst, 32'h201);
    chk("t2_drain_done", done, 0);
    rsp_pulse();
    chk("t2_os1", pio_cst, 32'h101);
    rsp_pulse();
    wait_done("t2_done");
    chk("t2_cst", pio_cst, 32'h4);
    rsp_pulse();
    chk("t2_extra_err", pio_cst, 32'h6);

    // set beats clear in the same cycle
    rsp_val = 1'b1;
    pio_cst_we = 1'b1;
    pio_d = 32'h2;
    tick();
    rsp_val = 1'b0;
    pio_cst_we = 1'b0;
    chk("setwin_err", err, 1);
    chk("setwin_os", pio_cst[15:8], 0);
    pio_wr(0, 0, 1, 32'h6);
    chk("clr_all", pio_cst, 0);

    // zero length
    pio_wr(0, 1, 0, 32'h0);
    chk("z_done", done, 1);
    chk("z_val", biu_val, 0);
    chk("z_cst", pio_cst, 32'h4);
    tick();
    chk("z_pulse", done, 0);

    // address and length in the same cycle
    fill = pops + 16;
    pio_wr(1, 1, 0, 32'h40);
    chk("same_adr", pio_adr, 32'h40);
    chk("same_len", pio_len, 32'h40);
    wait_val("same_start");
    burst("same", 32'h40, 0);
    rsp_pulse();
    wait_done("same_done");

    // address wrap
    fill = pops + 32;
    pio_wr(1, 0, 0, 32'hFFFF_FFC0);
    pio_wr(0, 1, 0, 32'h80);
    wait_val("wrap_a_start");
    burst("wrap_a", 32'hFFFF_FFC0, 0);
    wait_val("wrap_b_start");
    burst("wrap_b", 32'h0, 0);
    chk("wrap_adr", pio_adr, 32'h40);
    rsp_pulse();
    rsp_pulse();
    wait_done("wrap_done");
    chk("wrap_err", err, 0);

    // reset mid-burst
    fill = pops + 16;
    pio_wr(1, 0, 0, 32'h3000);
    pio_wr(0, 1, 0, 32'h40);
    wait_val("mrst_start");
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_val", biu_val, 0);
    chk("mrst_ack", dff_ack, 0);
    chk("mrst_sob", biu_sob, 0);
    chk("mrst_cst", pio_cst, 0);
    chk("mrst_adr", pio_adr, 0);
    tick();
    rst = 1'b0;
    tick();

    // lagging level with holdoff
    fill1 = 31;
    pio_d = 32'h5000;
    p1_adr_we = 1'b1;
    tick();
    p1_adr_we = 1'b0;
    pio_d = 32'h80;
    p1_len_we = 1'b1;
    tick();
    p1_len_we = 1'b0;
    k = 0;
    while (pops1 < 16 && k < 60) begin
      tick();
      k++;
    end
    repeat (20) tick();
    chk("lag_pops1", 32'(pops1), 16);
    chk("lag_val1", val1, 0);
    chk("lag_busy1", pio_cst1[0], 1);
    fill1 = 32;
    k = 0;
    while (pops1 < 32 && k < 60) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk("lag_pops2", 32'(pops1), 32);
    chk("lag_os", pio_cst1[15:8], 2);
    chk("lag_adr", pio_adr1, 32'h5080);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
